// File: rtl/i2c_write_ctrl_if.sv
// Signal bundle between host command logic, the byte stream source and the
// I2C pad buffers. The master modport is the sequencer side; slave is the
// host/pad side.
interface i2c_write_ctrl_if;
  logic       start;
  logic [6:0] addr;
  logic [7:0] len;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic       busy;
  logic       done;
  logic       nack;
  logic       scl_oe;
  logic       sda_oe;
  logic       sda_in;

  modport master (
    input  start, addr, len, wr_data, wr_valid, sda_in,
    output wr_ready, busy, done, nack, scl_oe, sda_oe
  );

  modport slave (
    output start, addr, len, wr_data, wr_valid, sda_in,
    input  wr_ready, busy, done, nack, scl_oe, sda_oe
  );
endinterface

// File: rtl/i2c_write_ctrl.sv
// Single-master I2C write sequencer: START, address+W, len data bytes pulled
// from a valid/ready stream with per-byte ACK check, then STOP. All pad
// enables and status outputs are registered and computed from the next
// state/phase so they line up with the state register.
module i2c_write_ctrl #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int CLK_DIV  = CLK_FREQ / 100_000,
  parameter int DIV_LEN  = 16
) (
  input  logic             clk,
  input  logic             rst,
  i2c_write_ctrl_if.master bus
);

  localparam int Q = CLK_DIV / 4;
  localparam logic [DIV_LEN-1:0] PH_Q    = DIV_LEN'(Q);
  localparam logic [DIV_LEN-1:0] PH_2Q   = DIV_LEN'(2 * Q);
  localparam logic [DIV_LEN-1:0] PH_3Q   = DIV_LEN'(3 * Q);
  localparam logic [DIV_LEN-1:0] PH_LAST = DIV_LEN'(CLK_DIV - 1);
  localparam logic [DIV_LEN-1:0] PH_ONE  = DIV_LEN'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_ADDR  = 3'd2,
    ST_DATA  = 3'd3,
    ST_ACK   = 3'd4,
    ST_LOAD  = 3'd5,
    ST_STOP  = 3'd6
  } state_t;

  state_t             state_r, next_state_s;
  logic [DIV_LEN-1:0] ph_r, next_ph_s;
  logic [2:0]         bit_r, next_bit_s;
  logic [7:0]         shreg_r, next_shreg_s;
  logic [7:0]         remaining_r, next_remaining_s;
  logic               ack_bad_r, next_ack_bad_s;
  logic               nack_r, next_nack_s;
  logic               done_r, next_done_s;
  logic               scl_oe_r, next_scl_oe_s;
  logic               sda_oe_r, next_sda_oe_s;
  logic               wr_ready_r;
  logic               busy_r;
  logic               ph_end_s;

  // Next-state, datapath updates and the targets of the registered outputs
  always_comb begin
    next_state_s     = state_r;
    next_ph_s        = ph_r + PH_ONE;
    next_bit_s       = bit_r;
    next_shreg_s     = shreg_r;
    next_remaining_s = remaining_r;
    next_ack_bad_s   = ack_bad_r;
    next_nack_s      = nack_r;
    next_done_s      = 1'b0;
    next_scl_oe_s    = 1'b0;
    next_sda_oe_s    = sda_oe_r;
    ph_end_s         = (ph_r == PH_LAST);

    case (state_r)
      ST_IDLE: begin
        next_ph_s = '0;
        // The cycle carrying done must not accept a new request.
        if (bus.start && !done_r) begin
          next_state_s     = ST_START;
          next_shreg_s     = {bus.addr, 1'b0};
          next_remaining_s = bus.len;
          next_nack_s      = 1'b0;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (ph_end_s) begin
          next_state_s = ST_ADDR;
          next_ph_s    = '0;
          next_bit_s   = 3'd7;
        end else begin
          next_state_s = ST_START;
        end
      end
      ST_ADDR, ST_DATA: begin
        if (ph_end_s) begin
          next_ph_s = '0;
          if (bit_r == 3'd0) begin
            next_state_s = ST_ACK;
          end else begin
            next_bit_s = bit_r - 3'd1;
          end
        end else begin
          next_state_s = state_r;
        end
      end
      ST_ACK: begin
        if (ph_r == PH_3Q) begin
          next_ack_bad_s = bus.sda_in;
        end else begin
          next_ack_bad_s = ack_bad_r;
        end
        if (ph_end_s) begin
          next_ph_s = '0;
          if (ack_bad_r) begin
            next_nack_s  = 1'b1;
            next_state_s = ST_STOP;
          end else if (remaining_r == 8'd0) begin
            next_state_s = ST_STOP;
          end else begin
            next_state_s = ST_LOAD;
          end
        end else begin
          next_state_s = ST_ACK;
        end
      end
      ST_LOAD: begin
        // SCL stays low here until the source offers a byte.
        next_ph_s = '0;
        if (bus.wr_valid && wr_ready_r) begin
          next_shreg_s     = bus.wr_data;
          next_remaining_s = remaining_r - 8'd1;
          next_bit_s       = 3'd7;
          next_state_s     = ST_DATA;
        end else begin
          next_state_s = ST_LOAD;
        end
      end
      ST_STOP: begin
        if (ph_end_s) begin
          next_state_s = ST_IDLE;
          next_ph_s    = '0;
          next_done_s  = 1'b1;
        end else begin
          next_state_s = ST_STOP;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
        next_ph_s    = '0;
      end
    endcase

    // Pad enables for the cycle the state register is about to enter.
    case (next_state_s)
      ST_IDLE: begin
        next_scl_oe_s = 1'b0;
        next_sda_oe_s = 1'b0;
      end
      ST_START: begin
        next_scl_oe_s = 1'b0;
        next_sda_oe_s = (next_ph_s >= PH_2Q);
      end
      ST_ADDR, ST_DATA: begin
        next_scl_oe_s = (next_ph_s < PH_2Q);
        if (next_ph_s == PH_Q) begin
          next_sda_oe_s = ~next_shreg_s[next_bit_s];
        end else begin
          next_sda_oe_s = sda_oe_r;
        end
      end
      ST_ACK: begin
        next_scl_oe_s = (next_ph_s < PH_2Q);
        if (next_ph_s == PH_Q) begin
          next_sda_oe_s = 1'b0;
        end else begin
          next_sda_oe_s = sda_oe_r;
        end
      end
      ST_LOAD: begin
        next_scl_oe_s = 1'b1;
        next_sda_oe_s = sda_oe_r;
      end
      ST_STOP: begin
        next_scl_oe_s = (next_ph_s < PH_2Q);
        next_sda_oe_s = (next_ph_s < PH_3Q);
      end
      default: begin
        next_scl_oe_s = 1'b0;
        next_sda_oe_s = 1'b0;
      end
    endcase
  end

  // State, phase counter, datapath and registered outputs with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      ph_r        <= '0;
      bit_r       <= 3'd0;
      shreg_r     <= 8'd0;
      remaining_r <= 8'd0;
      ack_bad_r   <= 1'b0;
      nack_r      <= 1'b0;
      done_r      <= 1'b0;
      scl_oe_r    <= 1'b0;
      sda_oe_r    <= 1'b0;
      wr_ready_r  <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      ph_r        <= next_ph_s;
      bit_r       <= next_bit_s;
      shreg_r     <= next_shreg_s;
      remaining_r <= next_remaining_s;
      ack_bad_r   <= next_ack_bad_s;
      nack_r      <= next_nack_s;
      done_r      <= next_done_s;
      scl_oe_r    <= next_scl_oe_s;
      sda_oe_r    <= next_sda_oe_s;
      wr_ready_r  <= (next_state_s == ST_LOAD);
      busy_r      <= (next_state_s != ST_IDLE);
    end
  end

  assign bus.wr_ready = wr_ready_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.nack     = nack_r;
  assign bus.scl_oe   = scl_oe_r;
  assign bus.sda_oe   = sda_oe_r;

endmodule

// File: tb/tb_i2c_write_ctrl.sv
// Bench for i2c_write_ctrl. A segment-level bus model (START, bit, ACK, LOAD,
// STOP waveforms) builds the expected per-cycle trace of a transaction; the
// run task compares the DUT against it every cycle and drives sda_in/wr_valid
// from the same trace. Literal done cycles and SDA bit strings pin the model.
module tb_i2c_write_ctrl;
  localparam int D = 8;
  localparam int Q = D / 4;

  typedef struct packed {
    logic scl;
    logic sda;
    logic busy;
    logic rdy;
    logic done;
    logic nack;
    logic sin;
    logic vld;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  i2c_write_ctrl_if bus();

  i2c_write_ctrl #(.CLK_FREQ(800_000), .CLK_DIV(D), .DIV_LEN(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t        exp_q[$];
  logic        model_nack;
  logic        prev_sda;
  logic [7:0]  data_q [0:3];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          done_at;
  int          hs_cnt;
  int          nbits;
  logic [63:0] bits_r;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic add(input logic scl, input logic sda, input logic rdy, input logic sin, input logic vld);
    exp_t e;
    e.scl = scl; e.sda = sda; e.busy = 1'b1; e.rdy = rdy; e.done = 1'b0;
    e.nack = model_nack; e.sin = sin; e.vld = vld;
    exp_q.push_back(e);
  endtask

  task automatic seg_start();
    for (int p = 0; p < D; p++) add(1'b0, (p >= 2 * Q), 1'b0, 1'b0, 1'b1);
    prev_sda = 1'b1;
  endtask

  task automatic seg_bit(input logic v);
    for (int p = 0; p < D; p++) add((p < 2 * Q), (p < Q) ? prev_sda : ~v, 1'b0, 1'b0, 1'b1);
    prev_sda = ~v;
  endtask

  task automatic seg_ack(input logic bad);
    for (int p = 0; p < D; p++)
      add((p < 2 * Q), (p < Q) ? prev_sda : 1'b0, 1'b0, (p == 3 * Q) ? bad : ~bad, 1'b1);
    prev_sda = 1'b0;
    if (bad) model_nack = 1'b1;
  endtask

  task automatic seg_load(input int stall);
    for (int i = 0; i <= stall; i++) add(1'b1, prev_sda, 1'b1, 1'b0, (i == stall));
  endtask

  task automatic seg_stop();
    for (int p = 0; p < D; p++) add((p < 2 * Q), (p < 3 * Q), 1'b0, 1'b0, 1'b1);
    prev_sda = 1'b0;
  endtask

  task automatic seg_byte(input logic [7:0] b);
    for (int k = 7; k >= 0; k--) seg_bit(b[k]);
  endtask

  // nack_at: 0 = address byte NACKed, k = data byte k NACKed, -1 = all ACKed
  task automatic build(input logic [6:0] a, input int n, input int nack_at, input int stall);
    exp_t e;
    exp_q.delete();
    model_nack = 1'b0;
    prev_sda   = 1'b0;
    seg_start();
    seg_byte({a, 1'b0});
    seg_ack(nack_at == 0);
    if (nack_at != 0) begin
      for (int k = 0; k < n; k++) begin
        seg_load((k == 0) ? stall : 0);
        seg_byte(data_q[k]);
        seg_ack(nack_at == k + 1);
        if (nack_at == k + 1) break;
      end
    end
    seg_stop();
    e = '0;
    e.done = 1'b1; e.nack = model_nack; e.vld = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic run_txn(input logic [6:0] a, input logic [7:0] n, input int nack_at,
                         input int stall, input bit hold_start, input int abort_at);
    exp_t e;
    int   byte_idx;
    logic last_scl;
    build(a, int'(n), nack_at, stall);
    done_at = 0; hs_cnt = 0; nbits = 0; bits_r = '0; byte_idx = 0; last_scl = 1'b0;
    @(negedge clk);
    bus.addr = a; bus.len = n; bus.start = 1'b1; bus.wr_valid = 1'b1;
    bus.wr_data = data_q[0]; bus.sda_in = 1'b1;
    @(posedge clk);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      e = exp_q[i];
      chk("scl_oe", 64'(bus.scl_oe), 64'(e.scl));
      chk("sda_oe", 64'(bus.sda_oe), 64'(e.sda));
      chk("busy", 64'(bus.busy), 64'(e.busy));
      chk("wr_ready", 64'(bus.wr_ready), 64'(e.rdy));
      chk("done", 64'(bus.done), 64'(e.done));
      chk("nack", 64'(bus.nack), 64'(e.nack));
      if (last_scl && !bus.scl_oe) begin
        bits_r = {bits_r[62:0], ~bus.sda_oe};
        nbits++;
      end
      last_scl = bus.scl_oe;
      if (bus.done) done_at = i + 1;
      bus.start    = hold_start;
      bus.sda_in   = e.sin;
      bus.wr_valid = e.vld;
      bus.wr_data  = data_q[byte_idx];
      if (bus.wr_ready && bus.wr_valid) begin
        hs_cnt++;
        if (byte_idx < 3) byte_idx++;
      end
      if (abort_at == i + 1) return;
    end
    @(negedge clk);
    chk("post_busy", 64'(bus.busy), 64'd0);
    chk("post_done", 64'(bus.done), 64'd0);
    chk("post_nack", 64'(bus.nack), 64'(model_nack));
    bus.start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.addr = 7'd0; bus.len = 8'd0; bus.wr_data = 8'd0;
    bus.wr_valid = 1'b0; bus.sda_in = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_scl_oe", 64'(bus.scl_oe), 64'd0);
    chk("rst_sda_oe", 64'(bus.sda_oe), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_nack", 64'(bus.nack), 64'd0);
    chk("rst_wr_ready", 64'(bus.wr_ready), 64'd0);
    rst = 1'b0;

    // Two ACKed data bytes
    data_q[0] = 8'hA5; data_q[1] = 8'h3C; data_q[2] = 8'h00; data_q[3] = 8'h00;
    run_txn(7'h50, 8'd2, -1, 0, 1'b0, 0);
    chk("s1_done_cycle", 64'(done_at), 64'd235);
    chk("s1_handshakes", 64'(hs_cnt), 64'd2);
    chk("s1_nack", 64'(bus.nack), 64'd0);
    chk("s1_nbits", 64'(nbits), 64'd28);
    chk("s1_sda_bits", {36'd0, bits_r[27:0]}, {36'd0, 8'hA0, 1'b1, 8'hA5, 1'b1, 8'h3C, 1'b1, 1'b0});

    // Address NACK
    data_q[0] = 8'h11; data_q[1] = 8'h22; data_q[2] = 8'h33;
    run_txn(7'h21, 8'd3, 0, 0, 1'b0, 0);
    chk("s2_done_cycle", 64'(done_at), 64'd89);
    chk("s2_handshakes", 64'(hs_cnt), 64'd0);
    chk("s2_nack", 64'(bus.nack), 64'd1);
    chk("s2_sda_bits", {54'd0, bits_r[9:0]}, {54'd0, 8'h42, 1'b1, 1'b0});

    // First data byte NACKed, start held high throughout (ignored while busy/done)
    data_q[0] = 8'h5A; data_q[1] = 8'hC3;
    run_txn(7'h3B, 8'd2, 1, 0, 1'b1, 0);
    chk("s3_done_cycle", 64'(done_at), 64'd162);
    chk("s3_handshakes", 64'(hs_cnt), 64'd1);
    chk("s3_nack", 64'(bus.nack), 64'd1);

    // One byte with the source stalling 20 cycles in LOAD; nack clears
    data_q[0] = 8'h96;
    run_txn(7'h0F, 8'd1, -1, 20, 1'b0, 0);
    chk("s4_done_cycle", 64'(done_at), 64'd182);
    chk("s4_handshakes", 64'(hs_cnt), 64'd1);
    chk("s4_nack", 64'(bus.nack), 64'd0);

    // Zero-length write
    run_txn(7'h7F, 8'd0, -1, 0, 1'b0, 0);
    chk("s5_done_cycle", 64'(done_at), 64'd89);
    chk("s5_handshakes", 64'(hs_cnt), 64'd0);

    // Reset in the middle of a data byte, then a clean transaction
    data_q[0] = 8'h81;
    run_txn(7'h33, 8'd1, -1, 0, 1'b0, 100);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("mid_rst_scl_oe", 64'(bus.scl_oe), 64'd0);
      chk("mid_rst_sda_oe", 64'(bus.sda_oe), 64'd0);
      chk("mid_rst_busy", 64'(bus.busy), 64'd0);
      chk("mid_rst_done", 64'(bus.done), 64'd0);
      chk("mid_rst_wr_ready", 64'(bus.wr_ready), 64'd0);
    end
    rst = 1'b0;
    run_txn(7'h50, 8'd0, -1, 0, 1'b0, 0);
    chk("s6_done_cycle", 64'(done_at), 64'd89);
    chk("s6_nack", 64'(bus.nack), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
